// File: rtl/twos_decoder_serial.sv
// Bit-serial two's-complement to sign/magnitude decoder.
// One operand bit is processed per clock, LSB first, through a single negate slice.
module twos_decoder_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Twos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Sign,
  output logic [WIDTH-1:0] Mag,
  output logic             Is_min,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] op_reg;
  logic [WIDTH-1:0] mag_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             sign_reg;
  logic             is_min_reg;

  logic op_bit;
  logic res_bit;
  logic carry_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   if (cnt_reg == LAST_BIT) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Negation as invert-plus-one, rippled serially: carry starts at 1 and
  // dies at the first zero of the inverted operand.
  always_comb begin
    op_bit     = op_reg[cnt_reg];
    res_bit    = sign_reg ? ((~op_bit) ^ carry_reg) : op_bit;
    carry_next = (~op_bit) & carry_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg     <= '0;
      mag_reg    <= '0;
      cnt_reg    <= '0;
      carry_reg  <= 1'b0;
      sign_reg   <= 1'b0;
      is_min_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_reg     <= Twos;
            sign_reg   <= Twos[WIDTH-1];
            is_min_reg <= (Twos == MIN_VAL);
            cnt_reg    <= '0;
            carry_reg  <= 1'b1;
          end
        end
        SHIFT: begin
          // Result bits enter at the MSB so bit 0 lands at Mag[0] after WIDTH shifts.
          mag_reg   <= {res_bit, mag_reg[WIDTH-1:1]};
          cnt_reg   <= cnt_reg + 1'b1;
          carry_reg <= carry_next;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg == SHIFT);
  assign out_valid = (state_reg == DONE);
  assign Sign      = sign_reg;
  assign Mag       = mag_reg;
  assign Is_min    = is_min_reg;

endmodule
